// File: rtl/sar_pkg.sv
// Shared types and helpers for the multi-channel SAR controller.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package sar_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SAMPLE  = 2'd1,
        CONVERT = 2'd2,
        DONE    = 2'd3
    } sar_state_e;

    localparam int MAX_CH = 32;

    // One S/H cycle, one cycle per bit and one DONE cycle.
    function automatic int min_period(input int num_bits);
        return num_bits + 2;
    endfunction

    // Lowest enabled channel above last, otherwise wrap to the lowest enabled channel.
    function automatic int next_channel(input logic [MAX_CH-1:0] mask,
                                        input int last,
                                        input int num_ch);
        int above;
        int lowest;
        above  = -1;
        lowest = -1;
        for (int i = MAX_CH - 1; i >= 0; i--) begin
            if (i < num_ch && mask[i]) begin
                lowest = i;
                if (i > last) begin
                    above = i;
                end
            end
        end
        if (above >= 0) begin
            return above;
        end
        return (lowest >= 0) ? lowest : 0;
    endfunction

endpackage

// File: rtl/sar_multi_ch_controller_if.sv
// Result stream: tagged conversion result with valid/ready and sticky overrun.
// Latency: none (wires only).
// Backpressure: consumer holds data_ready low; producer overwrites and flags overrun.
interface sar_multi_ch_controller_if #(
    parameter int NUM_BITS = 4,
    parameter int CH_W     = 2
);
    logic [NUM_BITS-1:0] data_out;
    logic [CH_W-1:0]     data_ch;
    logic                data_valid;
    logic                data_ready;
    logic                overrun;

    modport master (
        output data_out,
        output data_ch,
        output data_valid,
        output overrun,
        input  data_ready
    );

    modport slave (
        input  data_out,
        input  data_ch,
        input  data_valid,
        input  overrun,
        output data_ready
    );
endinterface

// File: rtl/sar_rr_picker.sv
// Round-robin channel picker over the enabled-channel mask.
// Latency: combinational.
// Backpressure: none.
module sar_rr_picker
    import sar_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2
) (
    input  logic [NUM_CH-1:0] ch_mask,
    input  logic [CH_W-1:0]   last_ch,
    output logic [CH_W-1:0]   next_ch
);

    logic [MAX_CH-1:0] mask_ext;

    always_comb begin
        mask_ext               = '0;
        mask_ext[NUM_CH-1:0]   = ch_mask;
        next_ch                = CH_W'(next_channel(mask_ext, int'(last_ch), NUM_CH));
    end

endmodule

// File: rtl/sar_multi_ch_controller.sv
// Multi-channel SAR sequencer: periodic sample pulse, bit search, tagged result output.
// Latency: sample_sig at t gives data_valid at t+NUM_BITS+2.
// Backpressure: none upstream; an unaccepted result is overwritten and overrun sticks.
module sar_multi_ch_controller
    import sar_pkg::*;
#(
    parameter int NUM_BITS = 4,
    parameter int NUM_CH   = 4,
    parameter int RATE_W   = 8
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic                                         enable,
    input  logic [RATE_W-1:0]                            rate_div,
    input  logic [NUM_CH-1:0]                            ch_mask,
    input  logic                                         cmp_out,
    output logic                                         sample_sig,
    output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] ch_sel,
    output logic [NUM_BITS-1:0]                          dac_code,
    output logic                                         busy,
    sar_multi_ch_controller_if.master                    res
);

    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int BIT_W = $clog2(NUM_BITS);
    localparam int MIN_P = min_period(NUM_BITS);
    localparam int CNT_W = (RATE_W > $clog2(MIN_P + 1)) ? RATE_W : $clog2(MIN_P + 1);

    localparam logic [1:0] ST_IDLE    = IDLE;
    localparam logic [1:0] ST_SAMPLE  = SAMPLE;
    localparam logic [1:0] ST_CONVERT = CONVERT;
    localparam logic [1:0] ST_DONE    = DONE;

    logic [1:0]          state;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    period;
    logic [CNT_W-1:0]    rate_clamped;
    logic                run;
    logic                tick;
    logic                start;
    logic [BIT_W-1:0]    bit_idx;
    logic [NUM_BITS-1:0] dac_next;
    logic [CH_W-1:0]     last_ch;
    logic [CH_W-1:0]     next_ch;

    sar_rr_picker #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_picker (
        .ch_mask (ch_mask),
        .last_ch (last_ch),
        .next_ch (next_ch)
    );

    always_comb begin
        rate_clamped = CNT_W'(rate_div);
        if (CNT_W'(rate_div) < CNT_W'(MIN_P)) begin
            rate_clamped = CNT_W'(MIN_P);
        end
    end

    // Tick fires on the last count of a period so the SAMPLE cycle lines up with count 0;
    // the first tick after enable rises comes straight away because run is still clear.
    assign tick  = enable && (!run || (cnt == period - CNT_W'(1)));
    assign start = tick && (ch_mask != '0) && ((state == ST_IDLE) || (state == ST_DONE));

    assign sample_sig = (state == ST_SAMPLE);
    assign busy       = (state != ST_IDLE);

    always_comb begin
        dac_next          = dac_code;
        dac_next[bit_idx] = cmp_out;
        if (bit_idx != '0) begin
            dac_next[bit_idx - BIT_W'(1)] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            period <= CNT_W'(MIN_P);
            run    <= 1'b0;
        end else if (!enable) begin
            cnt <= '0;
            run <= 1'b0;
        end else if (tick) begin
            cnt    <= '0;
            run    <= 1'b1;
            period <= rate_clamped;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // At the minimum period the next tick lands in DONE, so DONE may chain straight into SAMPLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            ch_sel   <= '0;
            last_ch  <= CH_W'(NUM_CH - 1);
            dac_code <= '0;
            bit_idx  <= '0;
        end else begin
            case (state)
                ST_SAMPLE: begin
                    state    <= ST_CONVERT;
                    dac_code <= {1'b1, {(NUM_BITS-1){1'b0}}};
                    bit_idx  <= BIT_W'(NUM_BITS - 1);
                end
                ST_CONVERT: begin
                    dac_code <= dac_next;
                    bit_idx  <= bit_idx - BIT_W'(1);
                    if (bit_idx == '0) begin
                        state <= ST_DONE;
                    end
                end
                default: begin
                    if (start) begin
                        state   <= ST_SAMPLE;
                        ch_sel  <= next_ch;
                        last_ch <= next_ch;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res.data_out   <= '0;
            res.data_ch    <= '0;
            res.data_valid <= 1'b0;
            res.overrun    <= 1'b0;
        end else if (state == ST_DONE) begin
            res.data_out   <= dac_code;
            res.data_ch    <= ch_sel;
            res.data_valid <= 1'b1;
            if (res.data_valid && !res.data_ready) begin
                res.overrun <= 1'b1;
            end
        end else if (res.data_valid && res.data_ready) begin
            res.data_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sar_multi_ch_controller.sv
// Scoreboard bench for the multi-channel SAR controller with a behavioural comparator.
module tb_sar_multi_ch_controller;

    localparam int NB  = 4;
    localparam int NC  = 4;
    localparam int RW  = 8;
    localparam int CW  = 2;
    localparam int LAT = NB + 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic [RW-1:0] rate_div = '0;
    logic [NC-1:0] ch_mask = '0;
    logic          cmp_out;
    logic          sample_sig;
    logic          busy;
    logic [CW-1:0] ch_sel;
    logic [NB-1:0] dac_code;
    logic [NB-1:0] vin [NC];

    sar_multi_ch_controller_if #(.NUM_BITS(NB), .CH_W(CW)) res ();

    sar_multi_ch_controller #(
        .NUM_BITS (NB),
        .NUM_CH   (NC),
        .RATE_W   (RW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .rate_div   (rate_div),
        .ch_mask    (ch_mask),
        .cmp_out    (cmp_out),
        .sample_sig (sample_sig),
        .ch_sel     (ch_sel),
        .dac_code   (dac_code),
        .busy       (busy),
        .res        (res)
    );

    always #5 clk = ~clk;

    // Ideal comparator for the selected channel's input voltage.
    assign cmp_out = (vin[ch_sel] >= dac_code);

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        int due;
        int ch;
        int val;
    } load_t;

    load_t         lq[$];
    int            cyc = 0;
    logic          m_valid = 1'b0;
    logic          m_ovr = 1'b0;
    int            m_ch = 0;
    int            m_dat = 0;
    int            model_last = NC - 1;
    logic          rdy_p = 1'b0;
    logic [NC-1:0] mask_p = '0;
    int            s_cyc = 0;
    int            s_ch = 0;
    logic          have_s = 1'b0;
    int            n_samples = 0;
    int            last_sample_cyc = -1;
    int            seg = 0;
    int            exp_per = 0;
    int            mon_seg = -1;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int pick(input logic [NC-1:0] m, input int last);
        for (int i = 1; i <= NC; i++) begin
            if (m[(last + i) % NC]) return (last + i) % NC;
        end
        return -1;
    endfunction

    // Trial code for bit k: already-resolved upper bits of Vin plus bit k set.
    function automatic int trial(input int v, input int k);
        return ((v >> (k + 1)) << (k + 1)) | (1 << k);
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            lq.delete();
            m_valid    = 1'b0;
            m_ovr      = 1'b0;
            model_last = NC - 1;
            have_s     = 1'b0;
            mon_seg    = -1;
            check("reset_outputs", {sample_sig, busy, res.data_valid, res.overrun,
                                    res.data_out, res.data_ch, ch_sel, dac_code}, 0);
        end else begin
            if (m_valid && rdy_p) m_valid = 1'b0;
            if (lq.size() > 0 && lq[0].due == cyc) begin
                if (m_valid) m_ovr = 1'b1;
                m_valid = 1'b1;
                m_ch    = lq[0].ch;
                m_dat   = lq[0].val;
                void'(lq.pop_front());
            end
            check("data_valid", res.data_valid, m_valid);
            check("overrun", res.overrun, m_ovr);
            if (m_valid && res.data_ready) begin
                check("data_out", res.data_out, m_dat);
                check("data_ch", res.data_ch, m_ch);
            end
            if (sample_sig) begin
                int ch;
                ch = pick(mask_p, model_last);
                check("sample_mask_nonzero", (mask_p != '0), 1);
                if (have_s) check("sample_spacing_min", (cyc - s_cyc >= LAT), 1);
                if (exp_per != 0 && mon_seg == seg) check("sample_period", cyc - s_cyc, exp_per);
                if (ch >= 0) begin
                    check("ch_sel", ch_sel, ch);
                    model_last = ch;
                    lq.push_back('{cyc + LAT, ch, int'(vin[ch])});
                    s_ch = ch;
                end
                s_cyc           = cyc;
                have_s          = 1'b1;
                mon_seg         = seg;
                n_samples++;
                last_sample_cyc = cyc;
            end else if (have_s && (cyc - s_cyc >= 1) && (cyc - s_cyc <= NB)) begin
                check("dac_trial", dac_code, trial(int'(vin[s_ch]), NB - (cyc - s_cyc)));
            end
            check("busy", busy, have_s && (cyc - s_cyc <= NB + 1));
            if (have_s && (cyc - s_cyc <= NB + 1)) check("ch_sel_stable", ch_sel, s_ch);
        end
        rdy_p  = res.data_ready;
        mask_p = ch_mask;
    end

    task automatic tick_n(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_sample(input string name);
        int n0;
        int k;
        n0 = n_samples;
        k  = 0;
        while (n_samples == n0 && k < 200) begin
            @(negedge clk);
            #1;
            k++;
        end
        check({name, "_seen"}, (n_samples != n0), 1);
    endtask

    task automatic wait_valid(input string name);
        int k;
        k = 0;
        while (!res.data_valid && k < 30) begin
            @(negedge clk);
            #1;
            k++;
        end
        check({name, "_valid_seen"}, res.data_valid, 1);
    endtask

    task automatic restart(input logic [NC-1:0] m, input int r, input int per);
        enable = 1'b0;
        tick_n(12);
        for (int i = 0; i < NC; i++) vin[i] = NB'($urandom_range(0, (1 << NB) - 1));
        ch_mask  = m;
        rate_div = RW'(r);
        exp_per  = per;
        seg++;
        enable   = 1'b1;
    endtask

    initial begin
        int s;
        int n0;
        int c0;
        int prev;
        int t2_ch [4] = '{1, 3, 1, 3};

        for (int i = 0; i < NC; i++) vin[i] = '0;
        res.data_ready = 1'b1;
        tick_n(3);
        rst_n = 1'b1;

        // Single channel, minimum period, Vin = 11.
        restart(4'b0001, 0, LAT);
        vin[0] = 4'd11;
        wait_sample("t1");
        check("t1_ch_sel", ch_sel, 0);
        s = last_sample_cyc;
        wait_valid("t1");
        check("t1_latency", cyc - s, LAT);
        check("t1_data_out", res.data_out, 11);
        check("t1_data_ch", res.data_ch, 0);
        tick_n(24);

        // Two channels alternating at a 20-cycle period.
        restart(4'b1010, 20, 20);
        prev = -1;
        for (int j = 0; j < 4; j++) begin
            wait_sample("t2");
            check("t2_ch_seq", ch_sel, t2_ch[j]);
            if (prev >= 0) check("t2_spacing", last_sample_cyc - prev, 20);
            prev = last_sample_cyc;
        end

        // Empty mask: ticks are ignored until a channel is enabled.
        restart(4'b0000, 0, 0);
        n0 = n_samples;
        tick_n(50);
        check("t3_no_sample", n_samples - n0, 0);
        check("t3_busy", busy, 0);
        ch_mask = 4'b0100;
        wait_sample("t3");
        check("t3_ch_sel", ch_sel, 2);

        // Enable drops mid-conversion; conversion finishes, then nothing until re-enable.
        wait_sample("t4");
        tick_n(2);
        enable = 1'b0;
        n0 = n_samples;
        wait_valid("t4");
        check("t4_data_out", res.data_out, vin[2]);
        check("t4_data_ch", res.data_ch, 2);
        tick_n(30);
        check("t4_no_sample", n_samples - n0, 0);
        enable = 1'b1;
        c0 = cyc;
        tick_n(2);
        check("t4_reenable_cycle", last_sample_cyc, c0 + 1);

        // Consumer stalls across two results.
        restart(4'b0001, 0, LAT);
        res.data_ready = 1'b0;
        wait_sample("t5");
        tick_n(7);
        check("t5_first_held", res.data_valid, 1);
        check("t5_no_overrun_yet", res.overrun, 0);
        tick_n(6);
        check("t5_overrun", res.overrun, 1);
        check("t5_overwritten_data", res.data_out, vin[0]);
        res.data_ready = 1'b1;
        tick_n(20);
        check("t5_overrun_sticky", res.overrun, 1);

        // Asynchronous reset in the middle of a conversion.
        restart(4'b0110, 0, LAT);
        wait_sample("t6");
        tick_n(2);
        rst_n = 1'b0;
        #1;
        check("t6_async_reset", {sample_sig, busy, res.data_valid, res.overrun,
                                 res.data_out, res.data_ch, ch_sel, dac_code}, 0);
        tick_n(3);
        rst_n = 1'b1;
        c0 = cyc;
        wait_sample("t6_after");
        check("t6_restart_cycle", last_sample_cyc, c0 + 1);
        check("t6_first_ch", ch_sel, 1);
        check("t6_overrun_cleared", res.overrun, 0);

        // Randomised backpressure, mask and rate changes.
        restart(4'b1111, 0, 0);
        for (int i = 0; i < 600; i++) begin
            res.data_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 49) == 0) ch_mask = NC'($urandom_range(1, (1 << NC) - 1));
            if ($urandom_range(0, 49) == 0) rate_div = RW'($urandom_range(0, 25));
            tick_n(1);
        end
        res.data_ready = 1'b1;
        enable = 1'b0;
        tick_n(20);
        check("queue_drained", lq.size(), 0);
        check("final_idle", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
